gray_counter: RTL and testbench

- Parametrised, registered Gray-code counter. It is the sequential successor to the team's combinational 4-bit binary-to-Gray converter.
- Holds a binary count and presents both the binary value and its Gray encoding, registered.
- Supports up/down counting, enable, and parallel load in either binary or Gray form, with on-the-fly Gray-to-binary conversion.
- Supports wrap or saturate modes, and produces a one-cycle boundary pulse.
- Used for FIFO pointers and clock-domain-crossing counters.

---
 rtl/gray_counter.sv | 113 +++++++++++
 tb/tb_gray_counter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
//   Registered up/down counter that presents its value in both binary and Gray
//   form. Intended for FIFO pointers and clock-domain-crossing counters, where
//   the Gray output must change by exactly one bit per step.
//
//   Parameters
//     WIDTH    : counter width in bits (2..32)
//     SATURATE : 0 = wrap modulo 2^WIDTH, 1 = hold at all-ones / zero
//     RST_VAL  : binary value taken on reset
//
//   Ports
//     clk          : sole clock, rising edge
//     rst          : synchronous, active-high reset
//     en           : count enable, one step per cycle
//     up_dn        : 1 = increment, 0 = decrement
//     load         : parallel load strobe (beats en)
//     load_is_gray : 1 = load_val is Gray-encoded, 0 = binary
//     load_val     : value to load
//     bin_q        : registered binary count
//     gray_q       : registered Gray count, always Gray(bin_q)
//     bound        : registered pulse, the last step wrapped or saturated
// -----------------------------------------------------------------------------
module gray_counter #(
  parameter int               WIDTH    = 4,
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             bound
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("gray_counter: WIDTH must be in 2..32");
  end

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down: each binary bit is the parity of all Gray
  // bits at or above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] next_bin;
  logic             next_bound;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;

  // One extra bit catches the carry out of an increment and the borrow out of
  // a decrement; either one marks a boundary crossing.
  assign inc_ext = {1'b0, bin_q} + ONE;
  assign dec_ext = {1'b0, bin_q} - ONE;

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    next_bin   = bin_q;
    next_bound = 1'b0;
    if (load) begin
      next_bin = load_is_gray ? gray_to_bin(load_val) : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (inc_ext[WIDTH]) begin
          next_bin   = SATURATE ? bin_q : inc_ext[WIDTH-1:0];
          next_bound = 1'b1;
        end else begin
          next_bin = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (dec_ext[WIDTH]) begin
          next_bin   = SATURATE ? bin_q : dec_ext[WIDTH-1:0];
          next_bound = 1'b1;
        end else begin
          next_bin = dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  // gray_q is registered from the next-state binary value so it is glitch-free
  // and never lags bin_q.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      bin_q  <= RST_VAL;
      gray_q <= bin_to_gray(RST_VAL);
      bound  <= 1'b0;
    end else begin
      bin_q  <= next_bin;
      gray_q <= bin_to_gray(next_bin);
      bound  <= next_bound;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_counter
//   Drives one stimulus stream into a wrap-mode and a saturate-mode instance
//   (WIDTH=4, RST_VAL=0). Each step pushes hand-computed expectations into a
//   queue; a monitor pops one entry per cycle and compares both instances.
// -----------------------------------------------------------------------------
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic       load_is_gray = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] bin_w, gray_w, bin_s, gray_s;
  logic       bound_w, bound_s;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(4'd0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .bin_q(bin_w), .gray_q(gray_w), .bound(bound_w)
  );

  gray_counter #(.WIDTH(4), .SATURATE(1'b1), .RST_VAL(4'd0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .bin_q(bin_s), .gray_q(gray_s), .bound(bound_s)
  );

  // Hand-written 4-bit Gray table indexed by binary value.
  logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  typedef struct {
    int         idx;
    logic [3:0] bin_w;
    logic       bnd_w;
    logic [3:0] bin_s;
    logic       bnd_s;
    logic       onebit;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %0h required %0h", name, idx, act, req);
    end
  endtask

  // Drive one cycle of inputs, then queue what both instances must show.
  task automatic step(input logic r, input logic e, input logic u,
                      input logic l, input logic lg, input logic [3:0] lv,
                      input logic [3:0] bw, input logic kw,
                      input logic [3:0] bs, input logic ks, input logic ob);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; up_dn = u; load = l; load_is_gray = lg; load_val = lv;
    @(posedge clk);
    x.idx = step_no; x.bin_w = bw; x.bnd_w = kw;
    x.bin_s = bs; x.bnd_s = ks; x.onebit = ob;
    exp_q.push_back(x);
    step_no++;
  endtask

  // Monitor: compares on the falling edge, away from the update edge.
  initial begin : monitor
    exp_t       x;
    logic [3:0] prev_gray_w;
    prev_gray_w = 4'd0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("bin_w",   x.idx, 32'(bin_w),   32'(x.bin_w));
        check("gray_w",  x.idx, 32'(gray_w),  32'(gray_tab[x.bin_w]));
        check("bound_w", x.idx, 32'(bound_w), 32'(x.bnd_w));
        check("bin_s",   x.idx, 32'(bin_s),   32'(x.bin_s));
        check("gray_s",  x.idx, 32'(gray_s),  32'(gray_tab[x.bin_s]));
        check("bound_s", x.idx, 32'(bound_s), 32'(x.bnd_s));
        if (x.onebit)
          check("gray_w_onebit", x.idx, 32'($countones(gray_w ^ prev_gray_w)), 32'd1);
        prev_gray_w = gray_w;
      end
    end
  end

  initial begin : stimulus
    //     rst en up ld lg lv       bin_w b_w  bin_s b_s  onebit
    step(1, 0, 1, 0, 0, 4'd0,  4'd0, 0, 4'd0, 0, 0);
    step(1, 0, 1, 0, 0, 4'd0,  4'd0, 0, 4'd0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0, 0);

    // Full up sweep: wrap instance rolls to 0, saturate instance sticks at 15.
    step(1, 0, 1, 0, 0, 4'd0,  4'd0, 0, 4'd0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) step(0, 1, 1, 0, 0, 4'd0, 4'd0, 1, 4'd15, 1, 1);
      else         step(0, 1, 1, 0, 0, 4'd0, 4'(i), 0, 4'(i), 0, 1);
    end

    // Down from 0 (wrap) / from 15 (saturate).
    step(0, 1, 0, 0, 0, 4'd0,  4'd15, 1, 4'd14, 0, 1);
    step(0, 1, 0, 0, 0, 4'd0,  4'd14, 0, 4'd13, 0, 1);

    // Loads win over en.
    step(0, 1, 1, 1, 0, 4'b1010, 4'd10, 0, 4'd10, 0, 0);
    step(0, 1, 1, 1, 1, 4'b0110, 4'd4,  0, 4'd4,  0, 0);
    step(0, 0, 1, 1, 1, 4'b1000, 4'd15, 0, 4'd15, 0, 0);

    // Saturate at top: bound 0,1,1,1 on the saturate instance.
    step(0, 0, 1, 1, 0, 4'b1110, 4'd14, 0, 4'd14, 0, 0);
    step(0, 1, 1, 0, 0, 4'd0,  4'd15, 0, 4'd15, 0, 1);
    step(0, 1, 1, 0, 0, 4'd0,  4'd0,  1, 4'd15, 1, 1);
    step(0, 1, 1, 0, 0, 4'd0,  4'd1,  0, 4'd15, 1, 1);
    step(0, 1, 1, 0, 0, 4'd0,  4'd2,  0, 4'd15, 1, 1);
    step(0, 1, 0, 0, 0, 4'd0,  4'd1,  0, 4'd14, 0, 1);

    // Saturate at bottom, then a hold drops bound.
    step(0, 0, 1, 1, 0, 4'b0001, 4'd1, 0, 4'd1, 0, 0);
    step(0, 1, 0, 0, 0, 4'd0,  4'd0,  0, 4'd0, 0, 1);
    step(0, 1, 0, 0, 0, 4'd0,  4'd15, 1, 4'd0, 1, 1);
    step(0, 0, 0, 0, 0, 4'd0,  4'd15, 0, 4'd0, 0, 0);
    step(0, 1, 0, 0, 0, 4'd0,  4'd14, 0, 4'd0, 1, 1);
    step(0, 1, 1, 0, 0, 4'd0,  4'd15, 0, 4'd1, 0, 1);

    // Reset overrides a coincident load and en, then counting resumes.
    step(0, 0, 1, 1, 0, 4'b0111, 4'd7, 0, 4'd7, 0, 0);
    step(1, 1, 1, 1, 0, 4'b0011, 4'd0, 0, 4'd0, 0, 0);
    step(0, 1, 1, 0, 0, 4'd0,  4'd1,  0, 4'd1, 0, 1);

    // Let the monitor drain; a leftover entry means it never caught up.
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    repeat (3) @(posedge clk);
    check("queue_drained", step_no, 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
